// File: rtl/conv_weight_loader_if.sv
// conv_weight_loader_if
//   Control, upstream weight stream and weight-bus signals of the
//   convolution weight loader, bundled for one connection.
//   master : the controlling/upstream side (drives i_*, observes o_*)
//   slave  : the loader itself (observes i_*, drives o_*)
//   i_start    start a weight-load sequence
//   i_clr      synchronous abort
//   i_w_valid  upstream weight beat valid
//   i_w_data   signed upstream weight
//   o_w_ready  loader accepts a beat this cycle
//   o_w_en     weight-bus write strobe
//   o_addr     weight-bus element address (row*KERNEL_SIZE + column)
//   o_w        signed weight-bus data
//   o_busy     load sequence in progress
//   o_done     one-cycle completion pulse
interface conv_weight_loader_if #(
   parameter int WEIGHT_BW = 8,
   parameter int ADDR_BW   = 5
);
   logic                        i_start;
   logic                        i_clr;
   logic                        i_w_valid;
   logic signed [WEIGHT_BW-1:0] i_w_data;
   logic                        o_w_ready;
   logic                        o_w_en;
   logic        [ADDR_BW-1:0]   o_addr;
   logic signed [WEIGHT_BW-1:0] o_w;
   logic                        o_busy;
   logic                        o_done;

   modport master (
      output i_start, i_clr, i_w_valid, i_w_data,
      input  o_w_ready, o_w_en, o_addr, o_w, o_busy, o_done
   );

   modport slave (
      input  i_start, i_clr, i_w_valid, i_w_data,
      output o_w_ready, o_w_en, o_addr, o_w, o_busy, o_done
   );
endinterface

// File: rtl/conv_weight_loader.sv
// conv_weight_loader
//   Streams KERNEL_SIZE*KERNEL_SIZE signed weights from a valid/ready
//   upstream onto the conv-row weight bus, one write per accepted beat,
//   addresses row-major from 0. A one-cycle o_done accompanies the final
//   write.
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    conv_weight_loader_if.slave (start/clear, weight stream, weight bus)
module conv_weight_loader #(
   parameter int KERNEL_SIZE = 5,
   parameter int WEIGHT_BW   = 8,
   parameter int ADDR_BW     = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   conv_weight_loader_if.slave   bus
);

   localparam int                 NUM_W     = KERNEL_SIZE * KERNEL_SIZE;
   localparam logic [ADDR_BW-1:0] LAST_ADDR = ADDR_BW'(NUM_W - 1);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t                      state;
   logic        [ADDR_BW-1:0]   cnt;
   logic                        ready;
   logic                        accept;

   logic                        vld_p1;
   logic        [ADDR_BW-1:0]   addr_p1;
   logic signed [WEIGHT_BW-1:0] w_p1;
   logic                        done_p1;
   logic                        busy_p1;

   // An abort in the same cycle must refuse the beat, so ready is gated by i_clr.
   assign ready  = (state == LOAD) && !bus.i_clr;
   assign accept = ready && bus.i_w_valid;

   // ---- stage p0 -> p1: beat acceptance to weight-bus write ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         vld_p1  <= 1'b0;
         addr_p1 <= '0;
         w_p1    <= '0;
         done_p1 <= 1'b0;
         busy_p1 <= 1'b0;
      end else begin
         vld_p1  <= accept;
         done_p1 <= 1'b0;
         if (accept) begin
            addr_p1 <= cnt;
            w_p1    <= bus.i_w_data;
         end

         case (state)
            IDLE: begin
               if (bus.i_start) begin
                  state   <= LOAD;
                  cnt     <= '0;
                  busy_p1 <= 1'b1;
               end
            end
            LOAD: begin
               if (accept) begin
                  if (cnt == LAST_ADDR) begin
                     // Counter parks on the last address; DONE carries the pulse.
                     state   <= DONE;
                     done_p1 <= 1'b1;
                  end else begin
                     cnt <= cnt + ADDR_BW'(1);
                  end
               end
            end
            DONE: begin
               state   <= IDLE;
               cnt     <= '0;
               busy_p1 <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               cnt     <= '0;
               busy_p1 <= 1'b0;
            end
         endcase

         // Abort overrides everything, including a simultaneous i_start.
         if (bus.i_clr) begin
            state   <= IDLE;
            cnt     <= '0;
            busy_p1 <= 1'b0;
         end
      end
   end

   assign bus.o_w_ready = ready;
   assign bus.o_w_en    = vld_p1;
   assign bus.o_addr    = addr_p1;
   assign bus.o_w       = w_p1;
   assign bus.o_done    = done_p1;
   assign bus.o_busy    = busy_p1;

endmodule

// File: tb/tb_conv_weight_loader.sv
module tb_conv_weight_loader;

   logic clk;
   logic rst_n;

   conv_weight_loader_if #(.WEIGHT_BW(8), .ADDR_BW(5)) bus ();

   conv_weight_loader #(
      .KERNEL_SIZE(5),
      .WEIGHT_BW  (8),
      .ADDR_BW    (5)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   logic        [4:0] wr_addr[$];
   logic signed [7:0] wr_data[$];
   int                done_cnt;
   int                done_misalign;
   int                busy_after_done;
   int                first_wr;
   int                last_wr;
   int                cyc = 0;
   logic              prev_done = 1'b0;
   logic signed [7:0] beat_data[25];

   // Observes registered outputs at the falling edge.
   always @(negedge clk) begin
      if (bus.o_w_en === 1'b1) begin
         wr_addr.push_back(bus.o_addr);
         wr_data.push_back(bus.o_w);
         if (first_wr < 0) first_wr = cyc;
         last_wr = cyc;
      end
      if (bus.o_done === 1'b1) begin
         done_cnt++;
         if (!(bus.o_w_en === 1'b1 && bus.o_addr === 5'd24)) done_misalign++;
      end
      if (prev_done === 1'b1 && bus.o_busy !== 1'b0) busy_after_done++;
      prev_done = bus.o_done;
      cyc++;
   end

   task automatic clear_mon();
      wr_addr.delete();
      wr_data.delete();
      done_cnt        = 0;
      done_misalign   = 0;
      busy_after_done = 0;
      first_wr        = -1;
      last_wr         = -1;
   endtask

   task automatic fill_ramp();
      for (int k = 0; k < 25; k++) beat_data[k] = 8'(k + 1);
   endtask

   // Drives start, n beats (optionally with a gap after each), then idles.
   task automatic run_load(input int n, input bit gaps, input bit start_pulses);
      @(negedge clk); bus.i_start = 1'b1;
      @(negedge clk); bus.i_start = 1'b0;
      for (int k = 0; k < n; k++) begin
         bus.i_w_valid = 1'b1;
         bus.i_w_data  = beat_data[k];
         bus.i_start   = (start_pulses && (k == 12 || k == 13));
         @(negedge clk);
         if (gaps) begin
            bus.i_w_valid = 1'b0;
            bus.i_w_data  = 8'sh55;
            @(negedge clk);
         end
      end
      bus.i_w_valid = 1'b0;
      bus.i_start   = start_pulses;
      @(negedge clk);
      bus.i_start   = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.i_start = 1'b0; bus.i_clr = 1'b0; bus.i_w_valid = 1'b0; bus.i_w_data = '0;
      repeat (2) @(negedge clk);
      vectors++; if (bus.o_w_en !== 1'b0) begin miscompares++; $display("FAIL reset_w_en got %b want 0", bus.o_w_en); end
      vectors++; if (bus.o_addr !== 5'd0) begin miscompares++; $display("FAIL reset_addr got %0d want 0", bus.o_addr); end
      vectors++; if (bus.o_w !== 8'sd0) begin miscompares++; $display("FAIL reset_w got %0d want 0", bus.o_w); end
      vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.o_busy); end
      vectors++; if (bus.o_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.o_done); end
      vectors++; if (bus.o_w_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", bus.o_w_ready); end
      rst_n = 1'b1;
      @(negedge clk);
      // Idle: valid alone must not be accepted.
      bus.i_w_valid = 1'b1;
      #1;
      vectors++; if (bus.o_w_ready !== 1'b0) begin miscompares++; $display("FAIL idle_ready got %b want 0", bus.o_w_ready); end
      @(negedge clk);
      bus.i_w_valid = 1'b0;
      vectors++; if (bus.o_w_en !== 1'b0) begin miscompares++; $display("FAIL idle_no_write got %b want 0", bus.o_w_en); end
   endtask

   task automatic test_back_to_back();
      fill_ramp();
      clear_mon();
      run_load(25, 1'b0, 1'b0);
      vectors++; if (wr_addr.size() != 25) begin miscompares++; $display("FAIL b2b_count got %0d want 25", wr_addr.size()); end
      for (int i = 0; i < 25 && i < wr_addr.size(); i++) begin
         vectors++; if (wr_addr[i] !== 5'(i)) begin miscompares++; $display("FAIL b2b_addr[%0d] got %0d want %0d", i, wr_addr[i], i); end
         vectors++; if (wr_data[i] !== 8'(i + 1)) begin miscompares++; $display("FAIL b2b_data[%0d] got %0d want %0d", i, wr_data[i], i + 1); end
      end
      vectors++; if (last_wr - first_wr != 24) begin miscompares++; $display("FAIL b2b_consecutive span got %0d want 24", last_wr - first_wr); end
      vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL b2b_done_count got %0d want 1", done_cnt); end
      vectors++; if (done_misalign != 0) begin miscompares++; $display("FAIL b2b_done_align got %0d want 0", done_misalign); end
      vectors++; if (busy_after_done != 0) begin miscompares++; $display("FAIL b2b_busy_after_done got %0d want 0", busy_after_done); end
   endtask

   task automatic test_valid_gaps();
      fill_ramp();
      clear_mon();
      run_load(25, 1'b1, 1'b0);
      vectors++; if (wr_addr.size() != 25) begin miscompares++; $display("FAIL gap_count got %0d want 25", wr_addr.size()); end
      for (int i = 0; i < 25 && i < wr_addr.size(); i++) begin
         vectors++; if (wr_addr[i] !== 5'(i)) begin miscompares++; $display("FAIL gap_addr[%0d] got %0d want %0d", i, wr_addr[i], i); end
         vectors++; if (wr_data[i] !== 8'(i + 1)) begin miscompares++; $display("FAIL gap_data[%0d] got %0d want %0d", i, wr_data[i], i + 1); end
      end
      vectors++; if (last_wr - first_wr != 48) begin miscompares++; $display("FAIL gap_span got %0d want 48", last_wr - first_wr); end
      vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL gap_done_count got %0d want 1", done_cnt); end
      vectors++; if (done_misalign != 0) begin miscompares++; $display("FAIL gap_done_align got %0d want 0", done_misalign); end
   endtask

   task automatic test_clear();
      fill_ramp();
      clear_mon();
      @(negedge clk); bus.i_start = 1'b1;
      @(negedge clk); bus.i_start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         bus.i_w_valid = 1'b1; bus.i_w_data = beat_data[k];
         @(negedge clk);
      end
      bus.i_clr = 1'b1; bus.i_w_data = 8'sh66;
      #1;
      vectors++; if (bus.o_w_ready !== 1'b0) begin miscompares++; $display("FAIL clr_ready got %b want 0", bus.o_w_ready); end
      @(negedge clk);
      bus.i_clr = 1'b0;
      repeat (5) @(negedge clk);
      bus.i_w_valid = 1'b0;
      @(negedge clk);
      vectors++; if (wr_addr.size() != 10) begin miscompares++; $display("FAIL clr_count got %0d want 10", wr_addr.size()); end
      for (int i = 0; i < 10 && i < wr_addr.size(); i++) begin
         vectors++; if (wr_addr[i] !== 5'(i)) begin miscompares++; $display("FAIL clr_addr[%0d] got %0d want %0d", i, wr_addr[i], i); end
      end
      vectors++; if (done_cnt != 0) begin miscompares++; $display("FAIL clr_done got %0d want 0", done_cnt); end
      vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL clr_busy got %b want 0", bus.o_busy); end
      // Start and clear together in IDLE: stays idle.
      bus.i_start = 1'b1; bus.i_clr = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0; bus.i_clr = 1'b0;
      vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL clr_start_busy got %b want 0", bus.o_busy); end
      // Restart begins at address 0.
      clear_mon();
      bus.i_start = 1'b1;
      @(negedge clk); bus.i_start = 1'b0;
      bus.i_w_valid = 1'b1; bus.i_w_data = 8'sd50;
      @(negedge clk); bus.i_w_valid = 1'b0;
      @(negedge clk);
      vectors++; if (wr_addr.size() != 1) begin miscompares++; $display("FAIL restart_count got %0d want 1", wr_addr.size()); end
      if (wr_addr.size() > 0) begin
         vectors++; if (wr_addr[0] !== 5'd0) begin miscompares++; $display("FAIL restart_addr got %0d want 0", wr_addr[0]); end
         vectors++; if (wr_data[0] !== 8'sd50) begin miscompares++; $display("FAIL restart_data got %0d want 50", wr_data[0]); end
      end
      bus.i_clr = 1'b1;
      @(negedge clk); bus.i_clr = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_load();
      fill_ramp();
      clear_mon();
      @(negedge clk); bus.i_start = 1'b1;
      @(negedge clk); bus.i_start = 1'b0;
      for (int k = 0; k < 7; k++) begin
         bus.i_w_valid = 1'b1; bus.i_w_data = beat_data[k];
         @(negedge clk);
      end
      // Beat 7's write is showing now; reset must clear it immediately.
      rst_n = 1'b0;
      #1;
      vectors++; if (bus.o_w_en !== 1'b0) begin miscompares++; $display("FAIL rstmid_w_en got %b want 0", bus.o_w_en); end
      vectors++; if (bus.o_addr !== 5'd0) begin miscompares++; $display("FAIL rstmid_addr got %0d want 0", bus.o_addr); end
      vectors++; if (bus.o_w !== 8'sd0) begin miscompares++; $display("FAIL rstmid_w got %0d want 0", bus.o_w); end
      vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b want 0", bus.o_busy); end
      vectors++; if (bus.o_w_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready got %b want 0", bus.o_w_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      bus.i_w_valid = 1'b0;
      @(negedge clk);
      vectors++; if (wr_addr.size() != 7) begin miscompares++; $display("FAIL rstmid_count got %0d want 7", wr_addr.size()); end
      vectors++; if (done_cnt != 0) begin miscompares++; $display("FAIL rstmid_done got %0d want 0", done_cnt); end
   endtask

   task automatic test_start_ignored();
      fill_ramp();
      clear_mon();
      run_load(25, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      vectors++; if (wr_addr.size() != 25) begin miscompares++; $display("FAIL startign_count got %0d want 25", wr_addr.size()); end
      if (wr_addr.size() == 25) begin
         vectors++; if (wr_addr[24] !== 5'd24) begin miscompares++; $display("FAIL startign_last_addr got %0d want 24", wr_addr[24]); end
         vectors++; if (wr_addr[13] !== 5'd13) begin miscompares++; $display("FAIL startign_mid_addr got %0d want 13", wr_addr[13]); end
      end
      vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL startign_done got %0d want 1", done_cnt); end
      vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL startign_busy got %b want 0", bus.o_busy); end
   endtask

   task automatic test_extremes();
      fill_ramp();
      beat_data[0]  = -8'sd128;
      beat_data[24] = 8'sd127;
      clear_mon();
      run_load(25, 1'b0, 1'b0);
      vectors++; if (wr_addr.size() != 25) begin miscompares++; $display("FAIL ext_count got %0d want 25", wr_addr.size()); end
      if (wr_addr.size() == 25) begin
         vectors++; if (wr_data[0] !== 8'h80) begin miscompares++; $display("FAIL ext_min got %h want 80", wr_data[0]); end
         vectors++; if (wr_data[24] !== 8'h7F) begin miscompares++; $display("FAIL ext_max got %h want 7f", wr_data[24]); end
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_valid_gaps();
      test_clear();
      test_reset_mid_load();
      test_start_ignored();
      test_extremes();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
